// File: rtl/camera_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : camera_capture_pkg                                           |
// | Description : Shared definitions for the camera write side of the frame    |
// |               buffer: screen geometry (also used by IMAGE_PROCESSOR),      |
// |               RGB332 field positions and capture FSM state encoding.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package camera_capture_pkg;

   // Frame-buffer geometry, shared with the reader side
   localparam int c_screen_width  = 176;
   localparam int c_screen_height = 144;
   localparam int c_addr_width    = 15;

   // RGB332 pixel layout {R[2:0], G[2:0], B[1:0]}
   localparam int c_rgb332_r_lsb = 5;
   localparam int c_rgb332_g_lsb = 2;
   localparam int c_rgb332_b_lsb = 0;

   // Capture FSM state encoding
   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      VBLANK    = 2'd1,
      FRAME     = 2'd2,
      LINE      = 2'd3
   } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/camera_capture_rgb565_to_rgb332.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rgb565_to_rgb332                                             |
// | Description : Combinational pack of an RGB565 byte pair (high byte first)  |
// |               into an 8-bit RGB332 pixel by keeping the top bits of each   |
// |               colour field.                                                |
// | Ports       : i_hi_byte - first camera byte  {R[4:0], G[5:3]}              |
// |               i_lo_byte - second camera byte {G[2:0], B[4:0]}              |
// |               o_pixel   - RGB332 result      {R[2:0], G[2:0], B[1:0]}      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rgb565_to_rgb332
   import camera_capture_pkg::*;
(
   input  logic [7:0] i_hi_byte,
   input  logic [7:0] i_lo_byte,
   output logic [7:0] o_pixel
);

   // Low-order colour bits are truncated away
   logic w_unused;
   assign w_unused = ^{i_hi_byte[4:3], i_lo_byte[7:5], i_lo_byte[2:0]};

   always_comb begin
      o_pixel = 8'h00;
      o_pixel[c_rgb332_r_lsb +: 3] = i_hi_byte[7:5];   // R[4:2]
      o_pixel[c_rgb332_g_lsb +: 3] = i_hi_byte[2:0];   // G[5:3]
      o_pixel[c_rgb332_b_lsb +: 2] = i_lo_byte[4:3];   // B[4:3]
   end

endmodule
`default_nettype wire

// File: rtl/camera_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : camera_capture                                               |
// | Description : Write side of the frame buffer. Samples the OV7670 RGB565    |
// |               byte stream, assembles pixels, downsamples to RGB332 and     |
// |               writes them at Y*SCREEN_WIDTH+X. Reports frame completion    |
// |               and the number of stored lines.                              |
// | Ports       : CLK, RESET_N        - pixel clock, async active-low reset    |
// |               CAM_DATA/HREF/VSYNC - camera byte bus and qualifiers         |
// |               CAPTURE_EN          - write enable, sampled per frame        |
// |               W_EN/WRITE_ADDRESS/PIXEL_OUT - frame-buffer write port       |
// |               FRAME_DONE, LINE_COUNT       - end-of-frame status           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module camera_capture
   import camera_capture_pkg::*;
#(
   parameter int SCREEN_WIDTH  = c_screen_width,
   parameter int SCREEN_HEIGHT = c_screen_height,
   parameter int ADDR_WIDTH    = c_addr_width
)(
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [7:0]            CAM_DATA,
   input  logic                  CAM_HREF,
   input  logic                  CAM_VSYNC,
   input  logic                  CAPTURE_EN,
   output logic                  W_EN,
   output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
   output logic [7:0]            PIXEL_OUT,
   output logic                  FRAME_DONE,
   output logic [7:0]            LINE_COUNT
);

   localparam int XW = $clog2(SCREEN_WIDTH + 1);
   localparam int YW = $clog2(SCREEN_HEIGHT + 1);

   localparam logic [XW-1:0]         c_x_max  = XW'(SCREEN_WIDTH);
   localparam logic [YW-1:0]         c_y_max  = YW'(SCREEN_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] c_line_step = ADDR_WIDTH'(SCREEN_WIDTH);

   cap_state_t r_state;
   cap_state_t w_state_nxt;

   logic [XW-1:0]         r_x;
   logic [YW-1:0]         r_y;
   logic [ADDR_WIDTH-1:0] r_base;      // Y*SCREEN_WIDTH, kept incrementally
   logic                  r_phase;
   logic [7:0]            r_hi_byte;
   logic                  r_frame_en;

   logic                  r_w_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_pixel;
   logic                  r_frame_done;
   logic [7:0]            r_line_count;

   logic                  w_sample;
   logic                  w_line_end;
   logic                  w_frame_end;
   logic                  w_frame_start;
   logic                  w_in_frame;
   logic                  w_wr_ok;
   logic [7:0]            w_pixel;

   rgb565_to_rgb332 u_pack (
      .i_hi_byte (r_hi_byte),
      .i_lo_byte (CAM_DATA),
      .o_pixel   (w_pixel)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= SYNC_WAIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and per-cycle control strobes. VSYNC is only ever low on
   // entry to FRAME, so seeing it high in FRAME/LINE is the rising edge;
   // it is checked first so that it wins over HREF.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_sample      = 1'b0;
      w_line_end    = 1'b0;
      w_frame_end   = 1'b0;
      w_frame_start = 1'b0;
      case (r_state)
         SYNC_WAIT: begin
            if (CAM_VSYNC) begin
               w_state_nxt = VBLANK;
            end
         end
         VBLANK: begin
            if (!CAM_VSYNC) begin
               w_frame_start = 1'b1;
               w_state_nxt   = FRAME;
            end
         end
         FRAME: begin
            if (CAM_VSYNC) begin
               w_frame_end = 1'b1;
               w_state_nxt = VBLANK;
            end else if (CAM_HREF) begin
               w_sample    = 1'b1;
               w_state_nxt = LINE;
            end
         end
         LINE: begin
            if (CAM_VSYNC) begin
               w_frame_end = 1'b1;
               w_state_nxt = VBLANK;
            end else if (CAM_HREF) begin
               w_sample = 1'b1;
            end else begin
               w_line_end  = 1'b1;
               w_state_nxt = FRAME;
            end
         end
         default: begin
            w_state_nxt = SYNC_WAIT;
         end
      endcase
   end

   assign w_in_frame = (r_state == FRAME) || (r_state == LINE);
   assign w_wr_ok    = r_frame_en && (r_x < c_x_max) && (r_y < c_y_max);

   // ---------------------------------------------------------------------
   // Pixel assembly, position tracking and registered write port
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_x          <= '0;
         r_y          <= '0;
         r_base       <= '0;
         r_phase      <= 1'b0;
         r_hi_byte    <= 8'h00;
         r_frame_en   <= 1'b0;
         r_w_en       <= 1'b0;
         r_addr       <= '0;
         r_pixel      <= 8'h00;
         r_frame_done <= 1'b0;
         r_line_count <= 8'h00;
      end else begin
         r_w_en       <= 1'b0;
         r_frame_done <= 1'b0;

         // Outside an active frame the position is held at the origin
         if (!w_in_frame) begin
            r_x     <= '0;
            r_y     <= '0;
            r_base  <= '0;
            r_phase <= 1'b0;
         end

         if (w_frame_start) begin
            r_frame_en <= CAPTURE_EN;
         end

         if (w_sample) begin
            if (!r_phase) begin
               r_hi_byte <= CAM_DATA;
               r_phase   <= 1'b1;
            end else begin
               r_phase <= 1'b0;
               if (r_x < c_x_max) begin
                  r_x <= r_x + XW'(1);
               end
               if (w_wr_ok) begin
                  r_w_en  <= 1'b1;
                  r_pixel <= w_pixel;
                  r_addr  <= r_base + ADDR_WIDTH'(r_x);
               end
            end
         end

         // HREF fall: any unpaired high byte is simply forgotten
         if (w_line_end) begin
            r_x     <= '0;
            r_phase <= 1'b0;
            if (r_y < c_y_max) begin
               r_y    <= r_y + YW'(1);
               r_base <= r_base + c_line_step;
            end
         end

         // Only completed lines are counted; r_y already saturates
         if (w_frame_end) begin
            r_frame_done <= 1'b1;
            r_line_count <= 8'(r_y);
            r_x          <= '0;
            r_y          <= '0;
            r_base       <= '0;
            r_phase      <= 1'b0;
         end
      end
   end

   assign W_EN          = r_w_en;
   assign WRITE_ADDRESS = r_addr;
   assign PIXEL_OUT     = r_pixel;
   assign FRAME_DONE    = r_frame_done;
   assign LINE_COUNT    = r_line_count;

endmodule
`default_nettype wire
